// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32 pipeline control logic.
package cpu_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EXE source operand; MEM beats WB, x0 never forwarded.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] exe_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_wr_en,
    input  logic [4:0] wb_rd,
    input  logic       wb_wr_en,
    output logic [1:0] sel
);

    // NOTE: default assignment first so every path drives sel and no latch is inferred.
    always_comb begin
        sel = FWD_RF;
        if (mem_wr_en && (mem_rd != 5'd0) && (mem_rd == exe_rs))
            sel = FWD_MEM;
        else if (wb_wr_en && (wb_rd != 5'd0) && (wb_rd == exe_rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, pipeline hold/flush control, divide sequencing and perf counters
// for the 5-stage RV32 pipeline.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNTW       = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [4:0]      id_rsA,
    input  logic [4:0]      id_rsB,
    input  logic            id_useA,
    input  logic            id_useB,
    input  logic [4:0]      exe_rsA,
    input  logic [4:0]      exe_rsB,
    input  logic [4:0]      exe_rd,
    input  logic            exe_wr_en,
    input  logic            exe_is_load,
    input  logic            exe_is_div,
    input  logic            exe_redirect,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            mem_wr_en,
    input  logic            wb_wr_en,
    output logic            pc_hold,
    output logic            if_id_hold,
    output logic            if_id_flush,
    output logic            id_exe_hold,
    output logic            id_exe_flush,
    output logic            exe_mem_flush,
    output logic [1:0]      fwdA,
    output logic [1:0]      fwdB,
    output logic            div_start,
    output logic            div_busy,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    localparam int DW = $clog2(DIV_CYCLES) + 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(DIV_CYCLES - 1);

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic          lu;
    logic          in_run;
    logic          in_div;
    logic          lu_stall;
    logic          redirect;
    logic          div_draining;

    fwd_unit u_fwd_a (
        .exe_rs    (exe_rsA),
        .mem_rd    (mem_rd),
        .mem_wr_en (mem_wr_en),
        .wb_rd     (wb_rd),
        .wb_wr_en  (wb_wr_en),
        .sel       (fwdA)
    );

    fwd_unit u_fwd_b (
        .exe_rs    (exe_rsB),
        .mem_rd    (mem_rd),
        .mem_wr_en (mem_wr_en),
        .wb_rd     (wb_rd),
        .wb_wr_en  (wb_wr_en),
        .sel       (fwdB)
    );

    assign lu = exe_is_load && exe_wr_en && (exe_rd != 5'd0) &&
                ((id_useA && (id_rsA == exe_rd)) || (id_useB && (id_rsB == exe_rd)));

    assign in_run = (state == RUN);
    assign in_div = (state == DIV);

    // A divide owns the pipeline; redirect in turn overrides the load-use bubble.
    assign redirect     = in_run && exe_redirect;
    assign lu_stall     = in_run && lu && !exe_redirect;
    assign div_draining = in_div && (div_cnt != '0);

    assign div_start     = in_run && exe_is_div && !exe_redirect;
    assign pc_hold       = in_div || lu_stall;
    assign if_id_hold    = in_div || lu_stall;
    assign if_id_flush   = redirect;
    assign id_exe_hold   = div_draining;
    assign id_exe_flush  = redirect || lu_stall;
    assign exe_mem_flush = div_draining;

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= RUN;
            div_cnt  <= '0;
            div_busy <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (div_start) begin
                        state    <= DIV;
                        div_cnt  <= DIV_LOAD;
                        div_busy <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_cnt == '0) begin
                        state    <= RUN;
                        div_busy <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    div_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold)
                stall_cnt <= stall_cnt + CNTW'(1);
            if (if_id_flush)
                flush_cnt <= flush_cnt + CNTW'(1);
        end
    end

endmodule
